layer_compositor: RTL and testbench

- Parametrised N-layer RGB compositor that generalises the top-level fixed bird/pipe/background priority mux.
- Takes per-layer on/rgb pairs from object engines, plus a background colour. Outputs a pixel-tick-registered 12-bit RGB to the VGA DAC.
- Adds per-layer enable, transparency colour key, a 2-stage pipeline and per-frame sticky overlap flags between layer 0 (player) and every other layer.
- Overlap flags feed the game FSM collision input.

---
 rtl/layer_pkg.sv | 13 +
 rtl/layer_priority_mux.sv | 25 ++
 rtl/layer_compositor.sv | 162 ++++++++++++++++
 tb/tb_layer_compositor.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/layer_pkg.sv
// Shared constants and the fade helper for the layer compositor.
package layer_pkg;

  localparam int          RGB_W           = 12;
  localparam logic [11:0] RGB_BLACK       = 12'h000;
  localparam logic [11:0] KEY_RGB_DEFAULT = 12'hF0F;

  // Dim a 4:4:4 colour by shifting each nibble right by the fade level.
  function automatic logic [11:0] fade_rgb(input logic [11:0] c, input logic [1:0] lvl);
    fade_rgb = {c[11:8] >> lvl, c[7:4] >> lvl, c[3:0] >> lvl};
  endfunction

endpackage

// File: rtl/layer_priority_mux.sv
// Lowest-index visible layer wins; background when no layer is visible.
module layer_priority_mux
  import layer_pkg::*;
#(
  parameter int N_LAYERS = 4
) (
  input  logic [N_LAYERS-1:0]       vis,
  input  logic [RGB_W*N_LAYERS-1:0] layer_rgb,
  input  logic [RGB_W-1:0]          bg_rgb,
  output logic [RGB_W-1:0]          rgb
);

  // Scan from the lowest priority upward so layer 0 is written last.
  always_comb begin
    rgb = bg_rgb;
    for (int k = N_LAYERS - 1; k >= 0; k--) begin
      if (vis[k]) begin
        rgb = layer_rgb[k*RGB_W +: RGB_W];
      end else begin
        rgb = rgb;
      end
    end
  end

endmodule

// File: rtl/layer_compositor.sv
// N-layer RGB compositor with colour key, 2-stage pipeline and per-frame overlap flags.
// Optional fade-to-black enabled by defining LAYER_COMPOSITOR_FADE_EN.
module layer_compositor
  import layer_pkg::*;
#(
  parameter int               N_LAYERS    = 4,
  parameter int               COORD_W     = 10,
  parameter logic [RGB_W-1:0] KEY_RGB     = KEY_RGB_DEFAULT,
  parameter int               FADE_FRAMES = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      pixel_tick,
  input  logic                      video_on,
  input  logic [COORD_W-1:0]        x,
  input  logic [COORD_W-1:0]        y,
  input  logic [N_LAYERS-1:0]       layer_en,
  input  logic [N_LAYERS-1:0]       layer_on,
  input  logic [RGB_W*N_LAYERS-1:0] layer_rgb,
  input  logic [RGB_W-1:0]          bg_rgb,
  input  logic                      fade_req,
  output logic [RGB_W-1:0]          rgb,
  output logic [N_LAYERS-2:0]       hit,
  output logic                      hit_any,
  output logic                      frame_done
);

  logic [N_LAYERS-1:0]       vis_s;
  logic [N_LAYERS-1:0]       vis_r;
  logic [RGB_W*N_LAYERS-1:0] layer_rgb_r;
  logic [RGB_W-1:0]          bg_r;
  logic                      von_r;
  logic                      sof_s;
  logic                      sof_r;
  logic [RGB_W-1:0]          mux_rgb_s;
  logic [RGB_W-1:0]          out_rgb_s;
  logic [RGB_W-1:0]          rgb_r;
  logic [N_LAYERS-2:0]       ovl_s;
  logic [N_LAYERS-2:0]       acc_r;
  logic [N_LAYERS-2:0]       hit_r;
  logic                      hit_any_r;
  logic                      frame_done_r;
  logic [1:0]                level_s;

  assign sof_s = (x == {COORD_W{1'b0}}) && (y == {COORD_W{1'b0}});

  // A layer is visible when enabled, in bounds and not the transparent key.
  always_comb begin
    vis_s = {N_LAYERS{1'b0}};
    for (int k = 0; k < N_LAYERS; k++) begin
      vis_s[k] = layer_en[k] & layer_on[k] & (layer_rgb[k*RGB_W +: RGB_W] != KEY_RGB);
    end
  end

  // Player-versus-layer overlap of the pixel held in stage 1, active video only.
  always_comb begin
    ovl_s = {(N_LAYERS-1){1'b0}};
    for (int k = 1; k < N_LAYERS; k++) begin
      ovl_s[k-1] = von_r & vis_r[0] & vis_r[k];
    end
  end

  // Stage 1 capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vis_r       <= {N_LAYERS{1'b0}};
      layer_rgb_r <= {(RGB_W*N_LAYERS){1'b0}};
      bg_r        <= RGB_BLACK;
      von_r       <= 1'b0;
      sof_r       <= 1'b0;
    end else if (pixel_tick) begin
      vis_r       <= vis_s;
      layer_rgb_r <= layer_rgb;
      bg_r        <= bg_rgb;
      von_r       <= video_on;
      sof_r       <= sof_s;
    end
  end

  layer_priority_mux #(
    .N_LAYERS (N_LAYERS)
  ) u_mux (
    .vis       (vis_r),
    .layer_rgb (layer_rgb_r),
    .bg_rgb    (bg_r),
    .rgb       (mux_rgb_s)
  );

`ifdef LAYER_COMPOSITOR_FADE_EN
  localparam logic [7:0] FADE_LAST = 8'(FADE_FRAMES - 1);

  logic [1:0] level_r;
  logic [7:0] fcnt_r;

  // Fade level steps once per FADE_FRAMES frames while requested; drops to 0 otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_r <= 2'd0;
      fcnt_r  <= 8'd0;
    end else if (pixel_tick && sof_r) begin
      if (fade_req) begin
        if (fcnt_r == FADE_LAST) begin
          fcnt_r <= 8'd0;
          if (level_r != 2'd3) begin
            level_r <= level_r + 2'd1;
          end
        end else begin
          fcnt_r <= fcnt_r + 8'd1;
        end
      end else begin
        level_r <= 2'd0;
        fcnt_r  <= 8'd0;
      end
    end
  end

  assign level_s = level_r;
`else
  logic unused_s;
  assign unused_s = fade_req ^ (FADE_FRAMES > 0);
  assign level_s  = 2'd0;
`endif

  assign out_rgb_s = von_r ? fade_rgb(mux_rgb_s, level_s) : RGB_BLACK;

  // Stage 2 output register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb_r <= RGB_BLACK;
    end else if (pixel_tick) begin
      rgb_r <= out_rgb_s;
    end
  end

  // Overlap accumulation; the (0,0) pixel seeds the new frame, not the old one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_r        <= {(N_LAYERS-1){1'b0}};
      hit_r        <= {(N_LAYERS-1){1'b0}};
      hit_any_r    <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= 1'b0;
      if (pixel_tick) begin
        if (sof_r) begin
          hit_r        <= acc_r;
          hit_any_r    <= |acc_r;
          acc_r        <= ovl_s;
          frame_done_r <= 1'b1;
        end else begin
          acc_r <= acc_r | ovl_s;
        end
      end
    end
  end

  assign rgb        = rgb_r;
  assign hit        = hit_r;
  assign hit_any    = hit_any_r;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_layer_compositor.sv
// Self-checking bench for layer_compositor: directed scenarios plus random frames vs. a pixel-level model.
module tb_layer_compositor;

  localparam int N  = 4;
  localparam int W  = 12;
  localparam int H  = 6;
  localparam int FF = 4;
  localparam logic [47:0] LC = {12'h789, 12'h456, 12'h123, 12'hABC};

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        pixel_tick = 1'b0;
  logic        video_on = 1'b0;
  logic [9:0]  x = 10'd0;
  logic [9:0]  y = 10'd0;
  logic [3:0]  layer_en = 4'h0;
  logic [3:0]  layer_on = 4'h0;
  logic [47:0] layer_rgb = 48'h0;
  logic [11:0] bg_rgb = 12'h000;
  logic        fade_req = 1'b0;
  logic [11:0] rgb;
  logic [2:0]  hit;
  logic        hit_any;
  logic        frame_done;

  layer_compositor #(.N_LAYERS(N), .COORD_W(10), .KEY_RGB(12'hF0F), .FADE_FRAMES(FF)) dut (
    .clk(clk), .reset(reset), .pixel_tick(pixel_tick), .video_on(video_on), .x(x), .y(y),
    .layer_en(layer_en), .layer_on(layer_on), .layer_rgb(layer_rgb), .bg_rgb(bg_rgb),
    .fade_req(fade_req), .rgb(rgb), .hit(hit), .hit_any(hit_any), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // reference model state
  logic [11:0] prev_col;
  logic [2:0]  prev_ov, macc, mhit;
  logic        prev_sof;
  int          mlevel, mfcnt;
  logic [11:0] exp_rgb;
  logic [2:0]  exp_hit;
  logic        exp_any, exp_fd;

  logic [11:0] cap_rgb;
  logic [2:0]  cap_hit;
  logic        cap_any, cap_fd;
  logic [11:0] cur_bg = 12'h0A5;
  int          reset_y = -1;

  function automatic logic [11:0] ref_colour(input logic von, input logic [3:0] en, input logic [3:0] on,
                                             input logic [47:0] rgbs, input logic [11:0] bg);
    if (!von) return 12'h000;
    for (int k = 0; k < N; k++)
      if (en[k] && on[k] && rgbs[k*12 +: 12] != 12'hF0F) return rgbs[k*12 +: 12];
    return bg;
  endfunction

  function automatic logic [2:0] ref_ov(input logic von, input logic [3:0] en, input logic [3:0] on,
                                        input logic [47:0] rgbs);
    logic [3:0] v;
    logic [2:0] o;
    for (int k = 0; k < N; k++) v[k] = en[k] && on[k] && rgbs[k*12 +: 12] != 12'hF0F;
    for (int k = 1; k < N; k++) o[k-1] = von && v[0] && v[k];
    return o;
  endfunction

  function automatic logic [11:0] scale(input logic [11:0] c, input int lvl);
    int d;
    d = 1 << lvl;
    return {4'(int'(c[11:8]) / d), 4'(int'(c[7:4]) / d), 4'(int'(c[3:0]) / d)};
  endfunction

  task automatic model_clear();
    prev_col = 12'h000; prev_ov = 3'b000; prev_sof = 1'b0;
    macc = 3'b000; mhit = 3'b000; mlevel = 0; mfcnt = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1; pixel_tick = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_clear();
  endtask

  task automatic idle(input int n);
    pixel_tick = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One ticked pixel; afterwards exp_* hold what the outputs must show.
  task automatic step(input logic [9:0] sx, input logic [9:0] sy, input logic svon, input logic [3:0] sen,
                      input logic [3:0] son, input logic [47:0] srgb, input logic [11:0] sbg);
    x = sx; y = sy; video_on = svon; layer_en = sen; layer_on = son; layer_rgb = srgb; bg_rgb = sbg;
    pixel_tick = 1'b1;
    @(posedge clk);
    #1 pixel_tick = 1'b0;
    exp_rgb = scale(prev_col, mlevel);
    exp_fd  = prev_sof;
    if (prev_sof) begin
      mhit = macc;
      macc = prev_ov;
`ifdef LAYER_COMPOSITOR_FADE_EN
      if (fade_req) begin
        if (mfcnt == FF - 1) begin
          mfcnt = 0;
          if (mlevel < 3) mlevel++;
        end else mfcnt++;
      end else begin
        mlevel = 0; mfcnt = 0;
      end
`endif
    end else macc = macc | prev_ov;
    exp_hit  = mhit;
    exp_any  = |mhit;
    prev_col = ref_colour(svon, sen, son, srgb, sbg);
    prev_ov  = ref_ov(svon, sen, son, srgb);
    prev_sof = (sx == 10'd0) && (sy == 10'd0);
  endtask

  task automatic run_frame(input int mode);
    logic [3:0] en, on;
    logic       von;
    for (int yi = 0; yi < H; yi++) begin
      for (int xi = 0; xi < W; xi++) begin
        if (reset_y == yi && xi == 0) do_reset();
        von = (xi < 10) && (yi < 5);
        en = 4'hF; on = 4'h0;
        case (mode)
          1: if (xi == 5 && yi == 3) on = 4'b0011;
          2: if (xi == 0 && yi == 0) on = 4'b0011;
          4: if (!von) on = 4'hF;
          5: begin en = 4'b0111; if (von) on = 4'b1001; end
          6: begin
            if (xi == 5 && yi == 1) on = 4'b0011;
            if (xi == 5 && yi == 3) on = 4'b0101;
          end
          default: ;
        endcase
        step(10'(xi), 10'(yi), von, en, on, LC, cur_bg);
        if (xi == 1 && yi == 0) begin cap_fd = frame_done; cap_hit = hit; cap_any = hit_any; end
        if (xi == W/2 && yi == H/2) cap_rgb = rgb;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    total += 4;
    if (rgb !== 12'h000) begin bad++; $display("FAIL reset_rgb got=%h want=000", rgb); end
    if (hit !== 3'b000) begin bad++; $display("FAIL reset_hit got=%b want=000", hit); end
    if (hit_any !== 1'b0) begin bad++; $display("FAIL reset_hit_any got=%b want=0", hit_any); end
    if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done got=%b want=0", frame_done); end
    do_reset();
  endtask

  task automatic test_priority();
    logic [47:0] c;
    c = {12'h789, 12'h00F, 12'h123, 12'h0F0};
    step(10'd5, 10'd3, 1'b1, 4'hF, 4'b0101, c, 12'h0A5);
    step(10'd5, 10'd3, 1'b1, 4'hF, 4'b0101, c, 12'h0A5);
    total++;
    if (rgb !== 12'h0F0) begin bad++; $display("FAIL prio_l0 got=%h want=0F0", rgb); end
    step(10'd5, 10'd3, 1'b1, 4'b1110, 4'b0101, c, 12'h0A5);
    step(10'd5, 10'd3, 1'b1, 4'b1110, 4'b0101, c, 12'h0A5);
    total++;
    if (rgb !== 12'h00F) begin bad++; $display("FAIL prio_l0_disabled got=%h want=00F", rgb); end
  endtask

  task automatic test_colour_key();
    logic [47:0] c;
    c = {12'h789, 12'h456, 12'h123, 12'hF0F};
    step(10'd6, 10'd3, 1'b1, 4'hF, 4'b0011, c, 12'h0A5);
    step(10'd6, 10'd3, 1'b1, 4'hF, 4'b0011, c, 12'h0A5);
    total++;
    if (rgb !== 12'h123) begin bad++; $display("FAIL key_rgb got=%h want=123", rgb); end
    run_frame(0);
    total += 2;
    if (cap_hit !== 3'b010) begin bad++; $display("FAIL key_hit got=%b want=010", cap_hit); end
    if (cap_any !== 1'b1) begin bad++; $display("FAIL key_hit_any got=%b want=1", cap_any); end
  endtask

  task automatic test_overlap();
    run_frame(1);
    run_frame(0);
    total += 3;
    if (cap_fd !== 1'b1) begin bad++; $display("FAIL ovl_frame_done got=%b want=1", cap_fd); end
    if (cap_hit !== 3'b001) begin bad++; $display("FAIL ovl_hit got=%b want=001", cap_hit); end
    if (cap_any !== 1'b1) begin bad++; $display("FAIL ovl_hit_any got=%b want=1", cap_any); end
    run_frame(0);
    total += 3;
    if (cap_fd !== 1'b1) begin bad++; $display("FAIL clean_frame_done got=%b want=1", cap_fd); end
    if (cap_hit !== 3'b000) begin bad++; $display("FAIL clean_hit got=%b want=000", cap_hit); end
    if (cap_any !== 1'b0) begin bad++; $display("FAIL clean_hit_any got=%b want=0", cap_any); end
  endtask

  task automatic test_sof_overlap();
    run_frame(2);
    total++;
    if (cap_hit !== 3'b000) begin bad++; $display("FAIL sof_same_frame got=%b want=000", cap_hit); end
    run_frame(0);
    total++;
    if (cap_hit !== 3'b001) begin bad++; $display("FAIL sof_next_frame got=%b want=001", cap_hit); end
  endtask

  task automatic test_video_off();
    step(10'd5, 10'd3, 1'b0, 4'hF, 4'hF, LC, 12'h0A5);
    step(10'd5, 10'd3, 1'b0, 4'hF, 4'hF, LC, 12'h0A5);
    total++;
    if (rgb !== 12'h000) begin bad++; $display("FAIL voff_rgb got=%h want=000", rgb); end
    run_frame(4);
    total++;
    if (cap_hit !== 3'b000) begin bad++; $display("FAIL voff_hit_a got=%b want=000", cap_hit); end
    run_frame(0);
    total++;
    if (cap_hit !== 3'b000) begin bad++; $display("FAIL voff_hit_b got=%b want=000", cap_hit); end
  endtask

  task automatic test_disabled();
    run_frame(5);
    total++;
    if (cap_rgb !== 12'hABC) begin bad++; $display("FAIL dis_rgb got=%h want=ABC", cap_rgb); end
    run_frame(0);
    total++;
    if (cap_hit !== 3'b000) begin bad++; $display("FAIL dis_hit got=%b want=000", cap_hit); end
  endtask

  task automatic test_hold();
    logic [11:0] r;
    step(10'd0, 10'd0, 1'b1, 4'hF, 4'h0, LC, 12'h0A5);
    r = rgb;
    idle(3);
    total += 2;
    if (rgb !== r) begin bad++; $display("FAIL hold_rgb got=%h want=%h", rgb, r); end
    if (frame_done !== 1'b0) begin bad++; $display("FAIL hold_frame_done got=%b want=0", frame_done); end
    step(10'd1, 10'd0, 1'b1, 4'hF, 4'h0, LC, 12'h0A5);
    total++;
    if (frame_done !== 1'b1) begin bad++; $display("FAIL hold_pulse got=%b want=1", frame_done); end
    idle(1);
    total++;
    if (frame_done !== 1'b0) begin bad++; $display("FAIL pulse_width got=%b want=0", frame_done); end
  endtask

  task automatic test_midreset();
    reset_y = 2;
    run_frame(6);
    reset_y = -1;
    run_frame(0);
    total++;
    if (cap_hit !== 3'b010) begin bad++; $display("FAIL midreset_hit got=%b want=010", cap_hit); end
  endtask

  task automatic test_random();
    logic [3:0]  en, on;
    logic [47:0] c;
    logic        von;
    for (int f = 0; f < 5; f++) begin
      for (int yi = 0; yi < H; yi++) begin
        for (int xi = 0; xi < W; xi++) begin
          von = (xi < 10) && (yi < 5);
          en  = 4'($urandom_range(0, 15)) | 4'($urandom_range(0, 15));
          on  = 4'($urandom_range(0, 15));
          for (int k = 0; k < N; k++)
            c[k*12 +: 12] = ($urandom_range(0, 3) == 0) ? 12'hF0F : 12'($urandom);
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
          step(10'(xi), 10'(yi), von, en, on, c, 12'($urandom));
          total += 4;
          if (rgb !== exp_rgb) begin bad++; $display("FAIL rand_rgb got=%h want=%h", rgb, exp_rgb); end
          if (hit !== exp_hit) begin bad++; $display("FAIL rand_hit got=%b want=%b", hit, exp_hit); end
          if (hit_any !== exp_any) begin bad++; $display("FAIL rand_hit_any got=%b want=%b", hit_any, exp_any); end
          if (frame_done !== exp_fd) begin bad++; $display("FAIL rand_frame_done got=%b want=%b", frame_done, exp_fd); end
        end
      end
    end
  endtask

`ifdef LAYER_COMPOSITOR_FADE_EN
  task automatic test_fade();
    logic [11:0] want;
    int lvl;
    do_reset();
    cur_bg = 12'hFFF;
    fade_req = 1'b1;
    for (int f = 0; f < 14; f++) begin
      run_frame(0);
      lvl = (f + 1) / 4;
      if (lvl > 3) lvl = 3;
      case (lvl)
        0: want = 12'hFFF;
        1: want = 12'h777;
        2: want = 12'h333;
        default: want = 12'h111;
      endcase
      total++;
      if (cap_rgb !== want) begin bad++; $display("FAIL fade_f%0d got=%h want=%h", f, cap_rgb, want); end
    end
    reset_y = 3;
    run_frame(0);
    reset_y = -1;
    run_frame(0);
    total++;
    if (cap_rgb !== 12'hFFF) begin bad++; $display("FAIL fade_reset got=%h want=FFF", cap_rgb); end
    fade_req = 1'b0;
    cur_bg = 12'h0A5;
  endtask
`endif

  initial begin
    model_clear();
    test_reset();
    test_priority();
    test_colour_key();
    test_overlap();
    test_sof_overlap();
    test_video_off();
    test_disabled();
    test_hold();
    test_midreset();
    test_random();
`ifdef LAYER_COMPOSITOR_FADE_EN
    test_fade();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
